// File: rtl/branch_redirect.sv
// Execute-side redirect controller: merges taken branches and exception redirects into one buffered fetch redirect.
// Latency: one cycle from accept to fetch_redirect_valid/flush_younger; backpressure via fetch_redirect_ready stalls execute.
module branch_redirect #(
    parameter int PC_W  = 32,
    parameter int GEN_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             exe_valid,
    input  logic             exe_branch_taken,
    input  logic [PC_W-1:0]  exe_target,
    input  logic             exc_valid,
    input  logic [PC_W-1:0]  exc_vector,
    output logic             fetch_redirect_valid,
    output logic [PC_W-1:0]  fetch_redirect_pc,
    input  logic             fetch_redirect_ready,
    output logic [GEN_W-1:0] fetch_redirect_gen,
    output logic             flush_younger,
    output logic             exe_stall
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             flush_q, flush_d;
    logic             br_req;
    logic             br_acc;
    logic             load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            gen_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            gen_q   <= gen_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        gen_d   = gen_q;
        flush_d = 1'b0;
        // The instruction in execute during a flush cycle is younger than the redirect, so it is ignored.
        br_req  = exe_valid && exe_branch_taken && !flush_q;
        br_acc  = br_req && !exc_valid && ((state_q == IDLE) || fetch_redirect_ready);
        load    = exc_valid || br_acc;
        if (load) begin
            // An exception overwrites any pending redirect whether or not fetch took it.
            state_d = PEND;
            pc_d    = exc_valid ? (exc_vector & ALIGN_MASK) : (exe_target & ALIGN_MASK);
            gen_d   = gen_q + GEN_W'(1);
            flush_d = 1'b1;
        end else if ((state_q == PEND) && fetch_redirect_ready) begin
            state_d = IDLE;
        end
    end

    assign fetch_redirect_valid = (state_q == PEND);
    assign fetch_redirect_pc    = pc_q;
    assign fetch_redirect_gen   = gen_q;
    assign flush_younger        = flush_q;
    assign exe_stall            = (state_q == PEND) && !fetch_redirect_ready && br_req;

endmodule

// File: tb/tb_branch_redirect.sv
// Randomized + directed scoreboard bench for branch_redirect against a per-cycle reference model.
module tb_branch_redirect;

    localparam int PC_W  = 32;
    localparam int GEN_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             exe_valid = 1'b0;
    logic             exe_branch_taken = 1'b0;
    logic [PC_W-1:0]  exe_target = '0;
    logic             exc_valid = 1'b0;
    logic [PC_W-1:0]  exc_vector = '0;
    logic             fetch_redirect_valid;
    logic [PC_W-1:0]  fetch_redirect_pc;
    logic             fetch_redirect_ready = 1'b0;
    logic [GEN_W-1:0] fetch_redirect_gen;
    logic             flush_younger;
    logic             exe_stall;

    branch_redirect #(.PC_W(PC_W), .GEN_W(GEN_W)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .exe_valid            (exe_valid),
        .exe_branch_taken     (exe_branch_taken),
        .exe_target           (exe_target),
        .exc_valid            (exc_valid),
        .exc_vector           (exc_vector),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .fetch_redirect_ready (fetch_redirect_ready),
        .fetch_redirect_gen   (fetch_redirect_gen),
        .flush_younger        (flush_younger),
        .exe_stall            (exe_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [1:0]  gen;
        logic        flush;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_exp = 0;
    int   hs_act = 0;

    // Reference model: what fetch should be seeing this cycle.
    bit          m_vld = 0;
    logic [31:0] m_pc = '0;
    int          m_gen = 0;
    bit          m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && fetch_redirect_valid && fetch_redirect_ready) hs_act++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", 32'(fetch_redirect_valid), 32'(e.vld));
            chk("pc",    fetch_redirect_pc,         e.pc);
            chk("gen",   32'(fetch_redirect_gen),   32'(e.gen));
            chk("flush", 32'(flush_younger),        32'(e.flush));
            chk("stall", 32'(exe_stall),            32'(e.stall));
        end
    end

    // Called just after a rising edge; drives one cycle of inputs and predicts that cycle's outputs.
    task automatic cycle(input bit ev, input bit tk, input logic [31:0] tgt,
                         input bit exc, input logic [31:0] vec, input bit rdy);
        exp_t e;
        bit   req;
        bit   load;
        exe_valid            = ev;
        exe_branch_taken     = tk;
        exe_target           = tgt;
        exc_valid            = exc;
        exc_vector           = vec;
        fetch_redirect_ready = rdy;
        req     = ev && tk && !m_flush;
        e.vld   = m_vld;
        e.pc    = m_pc;
        e.gen   = 2'(m_gen);
        e.flush = m_flush;
        e.stall = m_vld && !rdy && req;
        exp_q.push_back(e);
        if (m_vld && rdy) hs_exp++;
        load = 0;
        if (exc) begin
            m_pc = vec & 32'hFFFF_FFFC;
            load = 1;
        end else if (req && (!m_vld || rdy)) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            load = 1;
        end
        if (load) begin
            m_vld = 1;
            m_gen = (m_gen + 1) % 4;
        end else if (m_vld && rdy) begin
            m_vld = 0;
        end
        m_flush = load;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset away from any edge; outputs must clear immediately.
    task automatic do_reset();
        fetch_redirect_ready = 1'b0;
        exe_valid            = 1'b1;
        exe_branch_taken     = 1'b1;
        exc_valid            = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(fetch_redirect_valid), 0);
        chk("rst_pc",    fetch_redirect_pc,         0);
        chk("rst_gen",   32'(fetch_redirect_gen),   0);
        chk("rst_flush", 32'(flush_younger),        0);
        chk("rst_stall", 32'(exe_stall),            0);
        m_vld = 0; m_pc = '0; m_gen = 0; m_flush = 0;
        exe_valid        = 1'b0;
        exe_branch_taken = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [1:0] gen_seq [5];
        gen_seq[0] = 2'd1; gen_seq[1] = 2'd2; gen_seq[2] = 2'd3; gen_seq[3] = 2'd0; gen_seq[4] = 2'd1;

        #12;
        chk("init_valid", 32'(fetch_redirect_valid), 0);
        chk("init_pc",    fetch_redirect_pc,         0);
        chk("init_gen",   32'(fetch_redirect_gen),   0);
        chk("init_flush", 32'(flush_younger),        0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single taken branch, fetch ready.
        cycle(1, 1, 32'h0000_1003, 0, 0, 1);
        chk("t1_pc",  fetch_redirect_pc, 32'h1000);
        chk("t1_gen", 32'(fetch_redirect_gen), 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Backpressure then back-to-back accept when ready rises.
        cycle(1, 1, 32'h0000_2000, 0, 0, 0);
        repeat (3) cycle(1, 1, 32'h0000_2468, 0, 0, 0);
        chk("t2_hold_pc", fetch_redirect_pc, 32'h2000);
        cycle(1, 1, 32'h0000_2468, 0, 0, 1);
        chk("t2_pc", fetch_redirect_pc, 32'h2468);
        cycle(0, 0, 0, 0, 0, 1);

        // Exception replaces an unacknowledged branch redirect.
        cycle(1, 1, 32'h0000_3000, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0000_0700, 0);
        chk("t3_pc", fetch_redirect_pc, 32'h700);
        cycle(0, 0, 0, 0, 0, 1);

        // Exception and taken branch together: vector wins.
        cycle(1, 1, 32'h0000_4000, 1, 32'h0000_0803, 1);
        chk("t4_pc", fetch_redirect_pc, 32'h800);
        cycle(0, 0, 0, 0, 0, 1);

        // Non-taken branch is ignored.
        cycle(1, 0, 32'h0000_5000, 0, 0, 1);
        cycle(1, 0, 32'h0000_5000, 0, 0, 1);

        // Generation wrap from reset.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 32'h0000_6000 + 32'(i * 16), 0, 0, 1);
            chk("gen_seq", 32'(fetch_redirect_gen), 32'(gen_seq[i]));
            cycle(0, 0, 0, 0, 0, 1);
        end

        // Reset while a redirect is pending.
        cycle(1, 1, 32'h0000_7000, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1);
        end
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk("handshakes", 32'(hs_act), 32'(hs_exp));
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Execute-side redirect controller for the MR pipeline. It takes the resolved branch outcome (`branch_taken` plus target) from the execute stage, plus exception redirects from the exception unit. It turns them into a single buffered redirect request to fetch over a valid/ready handshake. It also issues a one-cycle younger-instruction flush and a 2-bit redirect generation tag, which fetch uses to discard stale in-flight fetches.

## Interface
Parameters:
- `PC_W`, 32: PC / target width.
- `GEN_W`, 2: redirect generation tag width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `exe_valid`  in  1  execute stage holds a valid, fault-free instruction this cycle.
- `exe_branch_taken`  in  1  branch condition result for that instruction.
- `exe_target`  in  PC_W  branch target address.
- `exc_valid`  in  1  exception redirect request; single-cycle pulse.
- `exc_vector`  in  PC_W  exception vector address.
- `fetch_redirect_valid`  out  1  redirect request to fetch.
- `fetch_redirect_pc`  out  PC_W  redirect address; bits [1:0] always 0.
- `fetch_redirect_ready`  in  1  fetch accepts the redirect.
- `fetch_redirect_gen`  out  GEN_W  current redirect generation.
- `flush_younger`  out  1  one-cycle pulse; squash all instructions younger than the redirecting one.
- `exe_stall`  out  1  execute must hold its current instruction.

## Operation
- States: IDLE (no redirect outstanding) and PEND (`fetch_redirect_valid`=1, waiting for ready).
- Load event: the redirect register (`pc`, `gen+1`) is written and `flush_younger` pulses in the following cycle.
- Branch accept condition: `exe_valid && exe_branch_taken && !flush_younger && !exc_valid`, and either state is IDLE or (PEND and `fetch_redirect_ready`=1).
- Branch accepted:
  - `fetch_redirect_pc` <= `{exe_target[PC_W-1:2],2'b00}`.
  - gen increments.
  - next state PEND.
- Exception:
  - `exc_valid`=1 in any state is a load event using `exc_vector`; next state PEND.
  - Any pending branch redirect is discarded, even if fetch is not ready.
  - A simultaneous taken branch is dropped.
- Handshake completes on an edge where `fetch_redirect_valid && fetch_redirect_ready`. With no new load event, the next state is IDLE.
- Back-to-back: if in PEND, ready=1, and a new branch or exception is accepted in the same cycle, the state stays PEND with the new pc. Gen increments once.
- `exe_stall` = PEND && !`fetch_redirect_ready` && `exe_valid` && `exe_branch_taken` && !`flush_younger`. It is combinational. A stalled branch is not accepted and is re-presented by execute.
- `exe_valid` with `exe_branch_taken`=0 is ignored; no state change.
- While `flush_younger`=1, all exe inputs are ignored (that instruction is younger and being squashed).
- gen is modulo 2^GEN_W and wraps 3 -> 0 silently.

## Timing
- Reset (async assert, sync release): state IDLE; `fetch_redirect_valid`=0; `fetch_redirect_pc`=0; `fetch_redirect_gen`=0; `flush_younger`=0.
  - `exe_stall`=0 follows from state IDLE.
  - A reset mid-PEND drops the request with no further handshake.
- Latency: branch or exception sampled at edge N produces, in cycle N+1:
  - `fetch_redirect_valid`=1;
  - new pc and gen;
  - `flush_younger`=1 for exactly one cycle.
- `flush_younger` comes straight from a register; it does not depend on `fetch_redirect_ready`.
- `fetch_redirect_pc` and `fetch_redirect_gen` stay stable while valid && !ready, except when replaced by an exception.
- Minimum redirect spacing is one cycle: a new branch cannot be accepted in the cycle `flush_younger`=1.
- `exe_stall` and the branch-acceptance logic read `fetch_redirect_ready` combinationally. `fetch_redirect_valid` must not depend on ready.

## Test plan
- Reset, then branch taken to 0x0000_1003 with ready=1 -> next cycle: valid=1, pc=0x0000_1000, gen=1, flush=1; following cycle valid=0, flush=0, state IDLE.
- Taken to 0x2000, ready held 0 for 3 cycles, second taken branch presented -> `exe_stall`=1 while ready=0; pc remains 0x2000. When ready rises, the second branch is accepted in the same cycle -> pc=that target, gen=2, one extra flush pulse.
- PEND on 0x3000 with ready=0, `exc_valid` with vector 0x700 -> next cycle pc=0x700, gen incremented once, flush=1; 0x3000 is never handshaken.
- `exc_valid` and a taken branch in the same cycle -> only the vector is issued; gen advances by 1.
- Five consecutive accepted redirects from reset -> gen sequence 1,2,3,0,1.
- `exe_valid`=1 with taken=0, and a taken branch during a flush cycle -> no state change, no flush, no stall.
- Assert `reset_n`=0 mid-PEND -> all outputs 0 immediately, without waiting for a clock edge.
